// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSB = 1'b1
    } owner_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [31:0] IO_ADDR_LO_DEF = 32'h0003_0000;
    localparam logic [31:0] IO_ADDR_HI_DEF = 32'h0003_0004;

    // Number of byte transfers for a size code; the illegal code 3 behaves as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store clients onto
// one 8-bit RAM port, splitting accesses into little-endian byte transfers.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter logic [31:0] IO_ADDR_LO = IO_ADDR_LO_DEF,
    parameter logic [31:0] IO_ADDR_HI = IO_ADDR_HI_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  n_q, n_d;
    logic [2:0]  k_q, k_d;
    logic [2:0]  k_prev;
    logic [31:0] buf_q, buf_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic        lsb_done_q, lsb_done_d;
    logic [31:0] lsb_rdata_q, lsb_rdata_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        io_stall;

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[8*idx +: 8];
    endfunction

    function automatic logic [31:0] set_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[8*idx +: 8] = b;
        return r;
    endfunction

    // A byte aimed at the IO window cannot go out while the UART buffer is full.
    assign io_stall = io_buffer_full && (mem_a_q >= IO_ADDR_LO) && (mem_a_q <= IO_ADDR_HI);

    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign lsb_done  = lsb_done_q;
    assign lsb_rdata = lsb_rdata_q;
    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q & rdy_in & ~io_stall;

    // State and output registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            base_q      <= '0;
            n_q         <= '0;
            k_q         <= '0;
            buf_q       <= '0;
            if_done_q   <= 1'b0;
            if_data_q   <= '0;
            lsb_done_q  <= 1'b0;
            lsb_rdata_q <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            base_q      <= base_d;
            n_q         <= n_d;
            k_q         <= k_d;
            buf_q       <= buf_d;
            if_done_q   <= if_done_d;
            if_data_q   <= if_data_d;
            lsb_done_q  <= lsb_done_d;
            lsb_rdata_q <= lsb_rdata_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
        end
    end

    // Arbitration, byte sequencing and read-data assembly.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        base_d      = base_q;
        n_d         = n_q;
        k_d         = k_q;
        k_prev      = k_q - 3'd1;
        buf_d       = buf_q;
        if_done_d   = 1'b0;
        if_data_d   = if_data_q;
        lsb_done_d  = 1'b0;
        lsb_rdata_d = lsb_rdata_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;

        case (state_q)
            ST_IDLE: begin
                mem_a_d    = '0;
                mem_dout_d = '0;
                mem_wr_d   = 1'b0;
                // While a done pulse is out the requester is still dropping its request.
                if (!if_done_q && !lsb_done_q) begin
                    if (lsb_req) begin
                        owner_d = OWN_LSB;
                        base_d  = lsb_addr;
                        n_d     = size_bytes(lsb_size);
                        k_d     = '0;
                        buf_d   = '0;
                        mem_a_d = lsb_addr;
                        if (lsb_wr) begin
                            state_d    = ST_WRITE;
                            mem_dout_d = lsb_wdata[7:0];
                            mem_wr_d   = 1'b1;
                        end else begin
                            state_d = ST_READ;
                        end
                    end else if (if_req) begin
                        owner_d = OWN_IF;
                        base_d  = if_addr;
                        n_d     = 3'd4;
                        k_d     = '0;
                        buf_d   = '0;
                        mem_a_d = if_addr;
                        state_d = ST_READ;
                    end
                end
            end

            ST_READ: begin
                // mem_din carries the byte addressed in the previous cycle.
                if (k_q != 3'd0) begin
                    buf_d = set_byte(buf_q, k_prev[1:0], mem_din);
                end
                if (clear) begin
                    state_d = ST_IDLE;
                    mem_a_d = '0;
                end else if (k_q == n_q) begin
                    state_d = ST_IDLE;
                    mem_a_d = '0;
                    if (owner_q == OWN_IF) begin
                        if_done_d = 1'b1;
                        if_data_d = buf_d;
                    end else begin
                        lsb_done_d  = 1'b1;
                        lsb_rdata_d = buf_d;
                    end
                end else begin
                    k_d = k_q + 3'd1;
                    if (k_d != n_q) begin
                        mem_a_d = base_q + {29'd0, k_d};
                    end
                end
            end

            ST_WRITE: begin
                // Stores are already committed, so clear is ignored here.
                if (!io_stall) begin
                    if (k_q == n_q - 3'd1) begin
                        state_d    = ST_IDLE;
                        lsb_done_d = 1'b1;
                        mem_a_d    = '0;
                        mem_dout_d = '0;
                        mem_wr_d   = 1'b0;
                    end else begin
                        k_d        = k_q + 3'd1;
                        mem_a_d    = base_q + {29'd0, k_d};
                        mem_dout_d = get_byte(lsb_wdata, k_d[1:0]);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: behavioural RAM plus a byte-array reference model.
module tb_mem_ctrl;
    import mem_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clear = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req = 1'b0;
    logic        lsb_wr = 1'b0;
    logic [1:0]  lsb_size = '0;
    logic [31:0] lsb_addr = '0;
    logic [31:0] lsb_wdata = '0;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int nchk = 0;
    int nerr = 0;

    logic [7:0]  ram  [logic [31:0]];
    logic [7:0]  refm [logic [31:0]];
    logic [7:0]  rd_next = '0;
    logic [39:0] wq [$];
    int          stall_cnt = 0;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : 8'h00;
    endfunction

    // RAM environment: writes land mid-cycle, read data appears one cycle after its address.
    always @(negedge clk_in) begin
        if (mem_wr) begin
            ram[mem_a] = mem_dout;
            wq.push_back({mem_a, mem_dout});
        end else if (mem_a == 32'h0003_0000) begin
            stall_cnt++;
        end
        rd_next = ram_rd(mem_a);
    end

    always begin
        @(posedge clk_in);
        #1;
        mem_din = rd_next;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_io(input logic [31:0] a);
        return (a >= 32'h0003_0000) && (a <= 32'h0003_0004);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = ref_rd(a + k);
        return w;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int k = 0; k < n; k++) refm[a + k] = d[8*k +: 8];
    endtask

    // One load/store transaction; stall = cycles of io_buffer_full after accept,
    // frz = cycles of rdy_in low starting in cycle 2, clr_at = cycle offset of a clear pulse.
    task automatic do_lsb(input string tag, input logic wr, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int stall, input int frz, input int clr_at);
        int n, cyc, exp_lat;
        logic [31:0] exp;
        bit seen;
        n = nbytes(sz);
        exp = wr ? 32'h0 : ref_load(addr, n);
        exp_lat = (wr ? n + (is_io(addr) ? stall : 0) : n + 1) + frz;
        wq.delete();
        lsb_req = 1'b1; lsb_wr = wr; lsb_size = sz; lsb_addr = addr; lsb_wdata = wd;
        io_buffer_full = (stall > 0);
        tick();
        cyc = 0;
        seen = 0;
        while (cyc < 60 && !seen) begin
            if (cyc == stall) io_buffer_full = 1'b0;
            if (frz > 0 && cyc == 1) rdy_in = 1'b0;
            if (frz > 0 && cyc == 1 + frz) rdy_in = 1'b1;
            clear = (cyc == clr_at);
            if (lsb_done) seen = 1;
            else begin
                tick();
                cyc++;
            end
        end
        chk({tag, " latency"}, 40'(cyc), 40'(exp_lat));
        lsb_req = 1'b0; clear = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
        if (!wr) begin
            chk({tag, " rdata"}, {8'h0, lsb_rdata}, {8'h0, exp});
        end else begin
            ref_store(addr, n, wd);
            chk({tag, " nwrites"}, 40'(wq.size()), 40'(n));
            for (int k = 0; k < n && k < wq.size(); k++)
                chk({tag, " wbyte"}, wq[k], {addr + k, wd[8*k +: 8]});
        end
        tick();
    endtask

    task automatic do_if(input string tag, input logic [31:0] addr);
        int cyc;
        logic [31:0] exp;
        exp = ref_load(addr, 4);
        if_req = 1'b1; if_addr = addr;
        tick();
        cyc = 0;
        while (cyc < 60 && !if_done) begin
            tick();
            cyc++;
        end
        chk({tag, " latency"}, 40'(cyc), 40'd5);
        chk({tag, " data"}, {8'h0, if_data}, {8'h0, exp});
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        int cnt, lat;
        logic [31:0] a, d;
        logic [1:0]  sz;

        for (int i = 0; i < 32'h400; i++) begin
            d[7:0] = 8'($urandom);
            ram[i] = d[7:0];
            refm[i] = d[7:0];
        end
        for (int i = 0; i < 4; i++) begin
            a = 32'hFFFF_FFFC + i;
            d[7:0] = 8'($urandom);
            ram[a] = d[7:0];
            refm[a] = d[7:0];
        end
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        refm[32'h100] = 8'h13; refm[32'h101] = 8'h05; refm[32'h102] = 8'h00; refm[32'h103] = 8'h00;
        ram[32'h300] = 8'h80; refm[32'h300] = 8'h80;

        tick(); tick();
        chk("reset outputs", {if_done, lsb_done, mem_wr, mem_dout, mem_a[28:0]}, 40'h0);
        chk("reset data", {8'h0, if_data | lsb_rdata}, 40'h0);
        rst_in = 1'b0;
        tick();

        // Directed cases.
        do_if("fetch 0x100", 32'h100);
        chk("fetch word", {8'h0, if_data}, 40'h0000_0513);
        do_lsb("sw 0x200", 1'b1, SZ_W, 32'h200, 32'hDEAD_BEEF, 0, 0, -1);
        do_lsb("lw 0x200", 1'b0, SZ_W, 32'h200, 32'h0, 0, 0, -1);

        // Simultaneous requests: load/store side wins.
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = SZ_B; lsb_addr = 32'h300;
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        cnt = 0; lat = 0;
        while (lat < 60 && !lsb_done) begin
            if (if_done) cnt++;
            tick();
            lat++;
        end
        chk("arb lsb latency", 40'(lat), 40'd2);
        chk("arb lb data", {8'h0, lsb_rdata}, 40'h0000_0080);
        chk("arb no early if_done", 40'(cnt), 40'd0);
        lsb_req = 1'b0;
        lat = 0;
        while (lat < 60 && !if_done) begin
            tick();
            lat++;
        end
        chk("arb if done seen", 40'(if_done), 40'd1);
        chk("arb if data", {8'h0, if_data}, 40'h0000_0513);
        if_req = 1'b0;
        tick();

        // Flush two cycles into a fetch.
        if_req = 1'b1; if_addr = 32'h104;
        tick(); tick(); tick();
        clear = 1'b1; if_req = 1'b0;
        tick();
        clear = 1'b0;
        chk("clear idle mem_a", {8'h0, mem_a}, 40'h0);
        cnt = 0;
        repeat (8) begin
            if (if_done) cnt++;
            tick();
        end
        chk("clear no if_done", 40'(cnt), 40'd0);

        // Flush on the very edge the fetch would complete.
        if_req = 1'b1; if_addr = 32'h108;
        tick();
        repeat (4) tick();
        clear = 1'b1; if_req = 1'b0;
        tick();
        clear = 1'b0;
        chk("late clear if_done", 40'(if_done), 40'd0);
        tick();

        do_lsb("sh with clear", 1'b1, SZ_H, 32'h220, 32'h0000_A55A, 0, 0, 1);
        do_lsb("lh 0x220", 1'b0, SZ_H, 32'h220, 32'h0, 0, 0, -1);

        stall_cnt = 0;
        do_lsb("sb io", 1'b1, SZ_B, 32'h0003_0000, 32'h0000_0041, 3, 0, -1);
        chk("io stall cycles", 40'(stall_cnt), 40'd3);

        do_lsb("sw rdy freeze", 1'b1, SZ_W, 32'h240, 32'h1234_5678, 0, 3, -1);
        do_lsb("lw wrap", 1'b0, SZ_W, 32'hFFFF_FFFE, 32'h0, 0, 0, -1);

        // Reset in the middle of a word load.
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = SZ_W; lsb_addr = 32'h120;
        tick(); tick(); tick();
        rst_in = 1'b1;
        #1;
        chk("midreset ctrl", {if_done, lsb_done, mem_wr, mem_dout, mem_a[28:0]}, 40'h0);
        chk("midreset data", {8'h0, if_data | lsb_rdata}, 40'h0);
        lsb_req = 1'b0;
        tick();
        rst_in = 1'b0;
        tick();
        do_lsb("lw after reset", 1'b0, SZ_W, 32'h120, 32'h0, 0, 0, -1);

        // Randomised traffic against the reference memory.
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0: do_if("rnd fetch", 32'($urandom_range(0, 32'hFF)) << 2);
                1: begin
                    sz = 2'($urandom_range(0, 3));
                    do_lsb("rnd load", 1'b0, sz, 32'($urandom_range(0, 32'h3FC)), 32'h0, 0, 0, -1);
                end
                2: begin
                    sz = 2'($urandom_range(0, 3));
                    do_lsb("rnd store", 1'b1, sz, 32'($urandom_range(0, 32'h3FC)), $urandom,
                           $urandom_range(0, 2), 0, -1);
                end
                default: do_lsb("rnd io sb", 1'b1, SZ_B, 32'h0003_0000 + $urandom_range(0, 4),
                                $urandom, $urandom_range(0, 3), 0, -1);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
